// File: rtl/lstm_fx_pkg.sv
// Fixed-point defaults, FSM state type and saturation limits
// shared by the LSTM MAC sequencers and their post-processing.
package lstm_fx_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_FRAC_W = 8;
    localparam int DEF_ACC_W  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mac_state_t;

    localparam logic signed [DEF_DATA_W-1:0] SAT_MAX =
        {1'b0, {(DEF_DATA_W-1){1'b1}}};
    localparam logic signed [DEF_DATA_W-1:0] SAT_MIN =
        {1'b1, {(DEF_DATA_W-1){1'b0}}};

endpackage

// File: rtl/fx_shift_sat.sv
// Accumulator to fixed-point result: arithmetic shift right
// by FRAC_W, then clamp into the signed DATA_W range.
module fx_shift_sat
    import lstm_fx_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic [ACC_W-1:0]  acc,
    output logic [DATA_W-1:0] result
);

    localparam longint HI_L = (longint'(1) <<< (DATA_W - 1)) - 1;
    localparam logic signed [ACC_W-1:0] HI = ACC_W'(HI_L);
    localparam logic signed [ACC_W-1:0] LO = ACC_W'(-HI_L - 1);

    logic signed [ACC_W-1:0] shifted;

    assign shifted = $signed(acc) >>> FRAC_W;

    // Clamp the shifted value, otherwise pass its low bits through
    always_comb begin
        result = shifted[DATA_W-1:0];
        if (shifted > HI) begin
            result = HI[DATA_W-1:0];
        end else if (shifted < LO) begin
            result = LO[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/layer0_mac_sequencer.sv
// Layer-0 MAC initiator: streams N operand pairs from memory,
// accumulates onto the bias and presents a saturated result.
module layer0_mac_sequencer
    import lstm_fx_pkg::*;
#(
    parameter int N      = 9,
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int ACC_W  = DEF_ACC_W,
    localparam int AW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] bias,
    output logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] x_data,
    input  logic [DATA_W-1:0] w_data,
    output logic              ack,
    output logic              busy,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    input  logic              result_ready
);

    mac_state_t state;
    mac_state_t state_n;

    logic [AW-1:0]              idx;
    logic                       data_v;
    logic                       last_idx;
    logic signed [ACC_W-1:0]    acc;
    logic signed [2*DATA_W-1:0] prod;

    assign last_idx     = (idx == AW'(N - 1));
    assign prod         = $signed(x_data) * $signed(w_data);
    assign addr         = (state == RUN) ? idx : '0;
    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE);

    // State register, updated on the falling edge
    always_ff @(negedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic for the fetch/accumulate/hold sequence
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (start) state_n = RUN;
            RUN:   if (last_idx) state_n = DRAIN;
            DRAIN: if (data_v) state_n = DONE;
            DONE:  if (result_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Index counter, data-valid pipe, ack strobe and accumulator
    always_ff @(negedge clk) begin
        if (rst) begin
            idx    <= '0;
            data_v <= 1'b0;
            ack    <= 1'b0;
            acc    <= '0;
        end else begin
            data_v <= (state == RUN);
            ack    <= data_v;
            if (state == IDLE && start) begin
                acc <= ACC_W'($signed(bias)) <<< FRAC_W;
                idx <= '0;
            end else begin
                if (data_v) begin
                    acc <= acc + ACC_W'(prod);
                end
                if (state == RUN) begin
                    idx <= last_idx ? '0 : idx + AW'(1);
                end
            end
        end
    end

    fx_shift_sat #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_sat (
        .acc    (acc),
        .result (result)
    );

endmodule

// File: tb/tb_layer0_mac_sequencer.sv
// Directed scoreboard bench for layer0_mac_sequencer.
// DUT state moves on negedge; bench drives and samples on posedge.
module tb_layer0_mac_sequencer;

    localparam int N  = 9;
    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic [15:0]   bias;
    logic [AW-1:0] addr;
    logic [15:0]   x_data;
    logic [15:0]   w_data;
    logic          ack;
    logic          busy;
    logic [15:0]   result;
    logic          result_valid;
    logic          result_ready;

    logic [15:0] x_mem [N];
    logic [15:0] w_mem [N];

    logic [15:0] sb_q [$];
    int          checks;
    int          errors;
    int          ack_cnt;
    int          hs_cnt;
    logic        prev_valid;
    logic [15:0] prev_res;

    layer0_mac_sequencer #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bias         (bias),
        .addr         (addr),
        .x_data       (x_data),
        .w_data       (w_data),
        .ack          (ack),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous operand memories: one-cycle read latency
    always @(negedge clk) begin
        x_data <= x_mem[addr];
        w_data <= w_mem[addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard, ack accounting and result stability monitor
    always @(posedge clk) begin
        #1;
        if (ack) ack_cnt++;
        if (!busy) chk("ack_in_idle", {31'd0, ack}, 32'd0);
        if (result_valid && prev_valid)
            chk("result_stable", {16'd0, result}, {16'd0, prev_res});
        if (result_valid && result_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_underflow: observed %h expected none",
                       result);
            end else begin
                chk("result", {16'd0, result}, {16'd0, sb_q.pop_front()});
            end
            chk("ack_count", ack_cnt, N);
            ack_cnt = 0;
            hs_cnt++;
        end
        prev_valid = result_valid;
        prev_res   = result;
        if (rst) begin
            ack_cnt    = 0;
            prev_valid = 1'b0;
        end
    end

    task automatic fill(input logic [15:0] xv, input logic [15:0] wv);
        for (int i = 0; i < N; i++) begin
            x_mem[i] = xv;
            w_mem[i] = wv;
        end
    endtask

    // One transaction from the IDLE posedge; hold = ready-low cycles
    task automatic run_op(input logic [15:0] b, input logic [15:0] xv,
                          input logic [15:0] wv, input logic [15:0] exp,
                          input int hold);
        fill(xv, wv);
        bias         = b;
        start        = 1'b1;
        result_ready = (hold == 0);
        sb_q.push_back(exp);
        for (int c = 1; c <= N + 2; c++) begin
            @(posedge clk);
            if (c == 1) start = 1'b0;
            chk($sformatf("addr_c%0d", c), 32'(addr),
                (c <= N) ? 32'(c - 1) : 32'd0);
            chk($sformatf("ack_c%0d", c), {31'd0, ack},
                (c >= 3) ? 32'd1 : 32'd0);
            chk($sformatf("busy_c%0d", c), {31'd0, busy}, 32'd1);
            chk($sformatf("valid_c%0d", c), {31'd0, result_valid},
                (c == N + 2) ? 32'd1 : 32'd0);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            start = (h % 2 == 0);
            chk("bp_valid", {31'd0, result_valid}, 32'd1);
            chk("bp_ack", {31'd0, ack}, 32'd0);
            chk("bp_result", {16'd0, result}, {16'd0, exp});
        end
        if (hold > 0) begin
            start        = 1'b0;
            result_ready = 1'b1;
        end
        @(posedge clk);
        chk("post_hs_busy", {31'd0, busy}, 32'd0);
        chk("post_hs_valid", {31'd0, result_valid}, 32'd0);
        result_ready = 1'b0;
    endtask

    initial begin
        int target;
        int idle_len;
        logic seen_busy;
        checks       = 0;
        errors       = 0;
        ack_cnt      = 0;
        hs_cnt       = 0;
        prev_valid   = 1'b0;
        prev_res     = '0;
        rst          = 1'b1;
        start        = 1'b0;
        bias         = '0;
        result_ready = 1'b0;
        fill(16'h0000, 16'h0000);

        repeat (3) @(posedge clk);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        rst = 1'b0;
        @(posedge clk);

        run_op(16'h0000, 16'h0100, 16'h0100, 16'h0900, 0);
        run_op(16'h0200, 16'h0180, 16'hFF00, 16'hF480, 0);
        run_op(16'h0000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 0);
        run_op(16'h0000, 16'h7FFF, 16'h8000, 16'h8000, 0);
        run_op(16'h0200, 16'h0180, 16'hFF00, 16'hF480, 20);
        run_op(16'h0000, 16'h0100, 16'h0100, 16'h0900, 0);

        // Abort a run in cycle 5
        fill(16'h7FFF, 16'h7FFF);
        bias         = 16'h0200;
        result_ready = 1'b1;
        start        = 1'b1;
        @(posedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        rst = 1'b1;
        @(posedge clk);
        chk("abort_ack", {31'd0, ack}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_valid", {31'd0, result_valid}, 32'd0);
        chk("abort_addr", 32'(addr), 32'd0);
        chk("abort_result", {16'd0, result}, 32'd0);
        rst          = 1'b0;
        result_ready = 1'b0;
        @(posedge clk);
        run_op(16'h0000, 16'h0100, 16'h0100, 16'h0900, 0);

        // Back-to-back: start held, ready tied high
        fill(16'h0100, 16'h0100);
        bias         = 16'h0000;
        result_ready = 1'b1;
        repeat (3) sb_q.push_back(16'h0900);
        target    = hs_cnt + 3;
        idle_len  = 0;
        seen_busy = 1'b0;
        start     = 1'b1;
        for (int k = 0; k < 3 * (N + 4) + 10 && hs_cnt < target; k++) begin
            @(posedge clk);
            if (busy) begin
                if (seen_busy && idle_len != 0)
                    chk("b2b_idle_gap", idle_len, 1);
                idle_len  = 0;
                seen_busy = 1'b1;
            end else begin
                idle_len++;
            end
        end
        start = 1'b0;
        chk("b2b_handshakes", hs_cnt, target);
        repeat (3) @(posedge clk);
        result_ready = 1'b0;
        chk("b2b_end_busy", {31'd0, busy}, 32'd0);
        chk("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
